// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle combinational multiply path.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       state_dbg
);

  // Handshake: start is accepted only on an edge where busy=0; done pulses for
  // one cycle when HI/LO take a new mul/div result; busy covers start..FIN edge.
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [2*WIDTH-1:0]     acc;
  logic [WIDTH-1:0]       opb;
  logic [WIDTH-1:0]       raw_in1;
  logic [1:0]             op_q;
  logic                   neg_res;
  logic                   neg_rem;

  logic                   in1_neg, in2_neg;
  logic [WIDTH-1:0]       in1_abs, in2_abs;
  logic [WIDTH:0]         mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0]     mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]       fin_hi, fin_lo;

  // Signed ops (op[0]=0) work on magnitudes; sign is restored in FIN.
  assign in1_neg = ~op[0] & in1[WIDTH-1];
  assign in2_neg = ~op[0] & in2[WIDTH-1];
  assign in1_abs = in1_neg ? -in1 : in1;
  assign in2_abs = in2_neg ? -in2 : in2;

  // Multiply: multiplier sits in the low half and shifts out as the sum shifts in.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide: remainder in the high half, dividend/quotient bits in the low half.
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb};
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign prod_fix = neg_res ? -acc : acc;

  always_comb begin
    fin_hi = prod_fix[2*WIDTH-1:WIDTH];
    fin_lo = prod_fix[WIDTH-1:0];
    if (op_q[1]) begin
      if (opb == '0) begin
        fin_hi = raw_in1;
        fin_lo = '1;
      end else begin
        fin_hi = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        fin_lo = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      end
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = (2*WIDTH)'(in1_abs) * (2*WIDTH)'(in2_abs);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef MULDIV_FAST_MUL_EN
          state_nxt = op[1] ? CALC : FIN;
`else
          state_nxt = CALC;
`endif
        end
      end
      CALC:    if (cnt == LAST) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    state_dbg = state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      acc     <= '0;
      opb     <= '0;
      raw_in1 <= '0;
      op_q    <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            opb     <= in2_abs;
            raw_in1 <= in1;
            neg_res <= in1_neg ^ in2_neg;
            neg_rem <= in1_neg;
            cnt     <= '0;
`ifdef MULDIV_FAST_MUL_EN
            acc     <= op[1] ? {{WIDTH{1'b0}}, in1_abs} : fast_prod;
`else
            acc     <= {{WIDTH{1'b0}}, in1_abs};
`endif
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          cnt <= cnt + CNT_W'(1);
          acc <= op_q[1] ? div_next : mul_next;
        end
        FIN: begin
          hi   <= fin_hi;
          lo   <= fin_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
